// File: rtl/wb_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_sram_arbiter                                            |
// | Description : Three-master Wishbone arbiter in front of the shared SRAM  |
// |               controller. Round-robin grants with a bounded hold time,   |
// |               page-burst protection and a no-ack watchdog. One dead      |
// |               (IDLE) cycle separates consecutive grants.                 |
// | Ports       : clk, reset              clock, sync active-high reset      |
// |               mN_cyc/stb/we/adr/sel/dat_i   master N request (N=0..2)    |
// |               mN_dat_o / mN_ack_o / mN_err_o  read data, ack, abort      |
// |               s_cyc/stb/we/adr/sel/dat_o    muxed request to the slave   |
// |               s_dat_i, s_ack_i               slave response              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_sram_arbiter #(
   parameter int MAX_HOLD = 32,   // acks before a waiting master may preempt
   parameter int TIMEOUT  = 200,  // strobe cycles without ack before abort
   parameter int PAGE_BIT = 17    // address bit selecting page-read mode
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   input  logic        m2_cyc_i,
   input  logic        m2_stb_i,
   input  logic        m2_we_i,
   input  logic [31:0] m2_adr_i,
   input  logic [3:0]  m2_sel_i,
   input  logic [31:0] m2_dat_i,
   output logic [31:0] m2_dat_o,
   output logic        m2_ack_o,
   output logic        m2_err_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i
);

   localparam logic [0:0] c_IDLE     = 1'b0;
   localparam logic [0:0] c_BUSY     = 1'b1;
   localparam logic [1:0] c_NONE     = 2'd3;
   localparam logic [7:0] c_HOLD_MAX = 8'(MAX_HOLD);
   localparam logic [7:0] c_WD_LAST  = 8'(TIMEOUT - 1);

   logic [0:0] state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] last_q, last_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] wd_q, wd_d;

   logic [2:0] w_cyc, w_stb, w_req, w_gnt;
   logic [1:0] w_pick;
   logic       w_busy, w_wd_fire, w_preempt, w_release;

   assign w_cyc  = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
   assign w_stb  = {m2_stb_i, m1_stb_i, m0_stb_i};
   assign w_req  = w_cyc & w_stb;
   assign w_busy = (state_q == c_BUSY);

   // One-hot grant, all zero in IDLE so the slave side and acks stay quiet.
   assign w_gnt[0] = w_busy & (grant_q == 2'd0);
   assign w_gnt[1] = w_busy & (grant_q == 2'd1);
   assign w_gnt[2] = w_busy & (grant_q == 2'd2);

   assign s_cyc_o = |(w_gnt & w_cyc);
   assign s_stb_o = |(w_gnt & w_stb);
   assign s_we_o  = |(w_gnt & {m2_we_i, m1_we_i, m0_we_i});
   assign s_adr_o = ({32{w_gnt[0]}} & m0_adr_i) | ({32{w_gnt[1]}} & m1_adr_i)
                  | ({32{w_gnt[2]}} & m2_adr_i);
   assign s_sel_o = ({4{w_gnt[0]}} & m0_sel_i) | ({4{w_gnt[1]}} & m1_sel_i)
                  | ({4{w_gnt[2]}} & m2_sel_i);
   assign s_dat_o = ({32{w_gnt[0]}} & m0_dat_i) | ({32{w_gnt[1]}} & m1_dat_i)
                  | ({32{w_gnt[2]}} & m2_dat_i);

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m2_dat_o = s_dat_i;

   // Acks pass straight through to the owner; an ack seen in IDLE is dropped.
   assign {m2_ack_o, m1_ack_o, m0_ack_o} = w_gnt & {3{s_ack_i}};

   // Abort is decoded from the registered watchdog count so the error pulse
   // coincides with the release cycle.
   assign w_wd_fire = w_busy & (wd_q == c_WD_LAST) & ~s_ack_i;
   assign {m2_err_o, m1_err_o, m0_err_o} = w_gnt & {3{w_wd_fire}};

   // Never preempt on an ack cycle or in the middle of a page burst.
   assign w_preempt = (hold_q >= c_HOLD_MAX) & ~s_ack_i
                    & (|(w_req & ~w_gnt)) & ~s_adr_o[PAGE_BIT];
   assign w_release = w_busy & (w_wd_fire | ~s_cyc_o | w_preempt);

   // Round-robin search order: last+1, last+2, last (mod 3).
   always_comb begin
      w_pick = c_NONE;
      case (last_q)
         2'd0: begin
            if (w_req[1])      w_pick = 2'd1;
            else if (w_req[2]) w_pick = 2'd2;
            else if (w_req[0]) w_pick = 2'd0;
         end
         2'd1: begin
            if (w_req[2])      w_pick = 2'd2;
            else if (w_req[0]) w_pick = 2'd0;
            else if (w_req[1]) w_pick = 2'd1;
         end
         default: begin
            if (w_req[0])      w_pick = 2'd0;
            else if (w_req[1]) w_pick = 2'd1;
            else if (w_req[2]) w_pick = 2'd2;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      hold_d  = hold_q;
      wd_d    = wd_q;
      if (!w_busy) begin
         if (|w_req) begin
            state_d = c_BUSY;
            grant_d = w_pick;
            hold_d  = 8'd0;
            wd_d    = 8'd0;
         end
      end else if (w_release) begin
         state_d = c_IDLE;
         last_d  = grant_q;
         grant_d = c_NONE;
      end else begin
         if (s_ack_i && (hold_q != 8'hFF)) hold_d = hold_q + 8'd1;
         wd_d = (s_ack_i || !s_stb_o) ? 8'd0 : wd_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_IDLE;
         grant_q <= c_NONE;
         last_q  <= 2'd2;
         hold_q  <= 8'd0;
         wd_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         wd_q    <= wd_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_sram_arbiter                                         |
// | Description : Self-checking bench for wb_sram_arbiter: directed          |
// |               scenarios plus randomized traffic against a reference      |
// |               model of the arbitration rules.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_sram_arbiter;

   localparam int MAX_HOLD = 4;
   localparam int TIMEOUT  = 10;
   localparam int PAGE_BIT = 17;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cyc, stb, we;
   logic [31:0] adr [3];
   logic [31:0] wdat [3];
   logic [3:0]  sel [3];
   logic [31:0] s_dat_i;
   logic        s_ack_i;

   logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m1_ack_o, m2_ack_o, m0_err_o, m1_err_o, m2_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [2:0]  acks, errs;

   int n_checks = 0;
   int n_fail   = 0;

   assign acks = {m2_ack_o, m1_ack_o, m0_ack_o};
   assign errs = {m2_err_o, m1_err_o, m0_err_o};

   always #5 clk = ~clk;

   wb_sram_arbiter #(.MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT), .PAGE_BIT(PAGE_BIT)) dut (
      .clk(clk), .reset(reset),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
      .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
      .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_we_i(we[2]), .m2_adr_i(adr[2]),
      .m2_sel_i(sel[2]), .m2_dat_i(wdat[2]), .m2_dat_o(m2_dat_o),
      .m2_ack_o(m2_ack_o), .m2_err_o(m2_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
   );

   // Inputs change 1 time unit after the rising edge; outputs are read on
   // the falling edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      cyc = 3'b000; stb = 3'b000; we = 3'b000; s_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         adr[i] = 32'h0; wdat[i] = 32'h0; sel[i] = 4'h0;
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      s_dat_i = 32'hA5A5_5A5A;
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100; s_ack_i = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({s_cyc_o, s_stb_o, s_we_o, acks, errs} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000000", {s_cyc_o, s_stb_o, s_we_o, acks, errs});
      end
      n_checks++;
      if ({s_adr_o, s_sel_o, s_dat_o} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_bus: adr %h sel %h dat %h expected all zero", s_adr_o, s_sel_o, s_dat_o);
      end
      n_checks++;
      if ({m0_dat_o, m1_dat_o, m2_dat_o} !== {3{32'hA5A5_5A5A}}) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h %h %h expected a5a55a5a", m0_dat_o, m1_dat_o, m2_dat_o);
      end
      tick();
      reset = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_read;
      do_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100; sel[0] = 4'hF;
      @(negedge clk);
      n_checks++;
      if (s_stb_o !== 1'b0) begin
         n_fail++; $display("FAIL single_arb_cycle: s_stb_o %b expected 0", s_stb_o);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({s_stb_o, s_adr_o, s_sel_o} !== {1'b1, 32'h100, 4'hF}) begin
         n_fail++; $display("FAIL single_fwd: stb %b adr %h sel %h expected 1 00000100 f", s_stb_o, s_adr_o, s_sel_o);
      end
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if (acks !== 3'b000) begin
         n_fail++; $display("FAIL single_wait: acks %b expected 000", acks);
      end
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++;
      if ({acks, m0_dat_o} !== {3'b001, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL single_ack: acks %b dat %h expected 001 deadbeef", acks, m0_dat_o);
      end
      tick();
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_round_robin;
      int order[$];
      int ack_cyc[$];
      logic [2:0] a;
      do_reset();
      cyc = 3'b111; stb = 3'b111;
      adr[0] = 32'h1000; adr[1] = 32'h2000; adr[2] = 32'h3000;
      for (int c = 0; c < 30 && cyc != 3'b000; c++) begin
         #1;
         s_ack_i = s_stb_o;
         s_dat_i = 32'(c);
         @(negedge clk);
         a = acks;
         for (int m = 0; m < 3; m++)
            if (a[m]) begin order.push_back(m); ack_cyc.push_back(c); end
         tick();
         cyc = cyc & ~a; stb = stb & ~a; s_ack_i = 1'b0;
      end
      n_checks++;
      if (order.size() != 3) begin
         n_fail++; $display("FAIL rr_count: %0d grants expected 3", order.size());
      end else begin
         n_checks++;
         if (order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            n_fail++; $display("FAIL rr_order: got %0d %0d %0d expected 0 1 2", order[0], order[1], order[2]);
         end
         // ack, release on cyc drop, one IDLE cycle, next grant's ack
         n_checks++;
         if (ack_cyc[1] - ack_cyc[0] != 3 || ack_cyc[2] - ack_cyc[1] != 3) begin
            n_fail++; $display("FAIL rr_gap: spacing %0d %0d expected 3 3", ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_preempt;
      int m0_before = 0, m0_after = 0, last_m0 = -1, m1_first = -1, m1_acks = 0;
      int wr_ok = 0;
      logic prev = 1'b0;
      logic [2:0] a;
      do_reset();
      cyc = 3'b011; stb = 3'b011; we[0] = 1'b1;
      adr[0] = 32'h200; wdat[0] = 32'h1111_1111; sel[0] = 4'h3;
      adr[1] = 32'h300;
      for (int c = 0; c < 60 && cyc != 3'b000; c++) begin
         #1;
         s_ack_i = s_stb_o & ~prev;
         prev = s_ack_i;
         @(negedge clk);
         a = acks;
         if (s_stb_o && s_adr_o == 32'h300 && m1_first < 0) m1_first = c;
         if (a[0] && m1_acks == 0) begin
            m0_before++; last_m0 = c;
            if (s_we_o === 1'b1 && s_dat_o === 32'h1111_1111 && s_sel_o === 4'h3) wr_ok++;
         end
         if (a[0] && m1_acks > 0) m0_after++;
         if (a[1]) m1_acks++;
         tick();
         s_ack_i = 1'b0;
         if (a[1]) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
         if (a[0] && m1_acks > 0) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      end
      n_checks++;
      if (m0_before != MAX_HOLD) begin
         n_fail++; $display("FAIL preempt_hold: m0 got %0d acks before m1 expected %0d", m0_before, MAX_HOLD);
      end
      n_checks++;
      if (wr_ok != m0_before) begin
         n_fail++; $display("FAIL preempt_wdata: %0d of %0d write cycles forwarded correctly", wr_ok, m0_before);
      end
      // 4th ack, ack-free preempt cycle, dead cycle, then m1 strobe
      n_checks++;
      if (m1_first - last_m0 != 3) begin
         n_fail++; $display("FAIL preempt_latency: m1 strobe %0d cycles after last m0 ack expected 3", m1_first - last_m0);
      end
      n_checks++;
      if (m1_acks != 1 || m0_after != 1) begin
         n_fail++; $display("FAIL preempt_resume: m1 acks %0d m0 resumed acks %0d expected 1 1", m1_acks, m0_after);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_page_burst;
      int m2_acks = 0, m0_early = 0, m0_acks = 0;
      logic prev = 1'b0;
      logic [2:0] a;
      do_reset();
      cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 32'h0002_0040;
      adr[0] = 32'h500;
      for (int c = 0; c < 80 && !(m2_acks == 16 && m0_acks > 0); c++) begin
         if (c == 1) begin cyc[0] = 1'b1; stb[0] = 1'b1; end
         #1;
         s_ack_i = s_stb_o & ~prev;
         prev = s_ack_i;
         @(negedge clk);
         a = acks;
         if (a[2]) m2_acks++;
         if (a[0]) begin m0_acks++; if (m2_acks < 16) m0_early++; end
         tick();
         s_ack_i = 1'b0;
         if (m2_acks == 16) begin cyc[2] = 1'b0; stb[2] = 1'b0; end
         if (a[0]) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      end
      n_checks++;
      if (m2_acks != 16 || m0_early != 0) begin
         n_fail++; $display("FAIL page_burst: m2 acks %0d m0 acks inside burst %0d expected 16 0", m2_acks, m0_early);
      end
      n_checks++;
      if (m0_acks != 1) begin
         n_fail++; $display("FAIL page_after: m0 acks %0d expected 1", m0_acks);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_watchdog;
      int rise = -1, err_c = -1, n_err = 0;
      logic [2:0] bad_err = 3'b000;
      logic stray = 1'b0;
      do_reset();
      cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h600;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stray) begin
            n_checks++;
            if ({s_cyc_o, acks} !== 4'b0000) begin
               n_fail++; $display("FAIL wd_stray: s_cyc_o %b acks %b expected 0 000", s_cyc_o, acks);
            end
            break;
         end
         if (s_stb_o && rise < 0) rise = c;
         if (errs != 3'b000) begin
            n_err++; err_c = c; bad_err = bad_err | (errs & 3'b101);
         end
         tick();
         if (n_err > 0) begin
            cyc[1] = 1'b0; stb[1] = 1'b0; s_ack_i = 1'b1; stray = 1'b1;
         end
      end
      n_checks++;
      if (n_err != 1 || bad_err != 3'b000) begin
         n_fail++; $display("FAIL wd_pulse: %0d pulses, wrong-master bits %b expected 1 000", n_err, bad_err);
      end
      // wd_cnt counts 0..TIMEOUT-1 over the strobe cycles; abort on the last
      n_checks++;
      if (err_c - rise != TIMEOUT - 1) begin
         n_fail++; $display("FAIL wd_latency: err %0d cycles after strobe rise expected %0d", err_c - rise, TIMEOUT - 1);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid;
      do_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h700;
      tick();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_cyc_o !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_before: s_cyc_o %b expected 1", s_cyc_o);
      end
      tick();
      reset = 1'b0; s_ack_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({s_cyc_o, acks} !== 4'b0000) begin
         n_fail++; $display("FAIL rstmid_abort: s_cyc_o %b acks %b expected 0 000", s_cyc_o, acks);
      end
      tick();
      s_ack_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({s_stb_o, s_adr_o} !== {1'b1, 32'h700}) begin
         n_fail++; $display("FAIL rstmid_regrant: stb %b adr %h expected 1 00000700", s_stb_o, s_adr_o);
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_random;
      int owner = -1, last = 2, holds = 0, stall = 0, k, pct;
      logic [2:0] req, exp_ack, exp_err;
      logic       ex_cyc, ex_stb, ex_we, others, fire;
      logic [31:0] ex_adr, ex_dat;
      logic [3:0]  ex_sel;
      do_reset();
      for (int c = 0; c < 700; c++) begin
         pct = (c < 350) ? 50 : 6;
         for (int m = 0; m < 3; m++) begin
            if (cyc[m]) begin
               if ($urandom_range(0, 9) == 0) cyc[m] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) cyc[m] = 1'b1;
            stb[m]  = cyc[m] & ($urandom_range(0, 4) != 0);
            we[m]   = 1'($urandom_range(0, 1));
            adr[m]  = ($urandom() & 32'hFFFD_FFFF) | (($urandom_range(0, 3) == 0) ? 32'h0002_0000 : 32'h0);
            wdat[m] = $urandom();
            sel[m]  = 4'($urandom_range(0, 15));
         end
         s_ack_i = ($urandom_range(0, 99) < pct);
         s_dat_i = $urandom();
         @(negedge clk);
         req = cyc & stb;
         exp_ack = 3'b000; exp_err = 3'b000;
         ex_cyc = 1'b0; ex_stb = 1'b0; ex_we = 1'b0; ex_adr = 32'h0; ex_sel = 4'h0; ex_dat = 32'h0;
         fire = 1'b0;
         if (owner >= 0) begin
            ex_cyc = cyc[owner]; ex_stb = stb[owner]; ex_we = we[owner];
            ex_adr = adr[owner]; ex_sel = sel[owner]; ex_dat = wdat[owner];
            exp_ack[owner] = s_ack_i;
            fire = (stall == TIMEOUT - 1) && !s_ack_i;
            exp_err[owner] = fire;
         end
         n_checks++;
         if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== {ex_cyc, ex_stb, ex_we, ex_adr, ex_sel, ex_dat}) begin
            n_fail++;
            $display("FAIL rand_bus c=%0d: cyc%b stb%b we%b adr %h sel %h dat %h expected cyc%b stb%b we%b adr %h sel %h dat %h",
                     c, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, ex_cyc, ex_stb, ex_we, ex_adr, ex_sel, ex_dat);
         end
         n_checks++;
         if ({acks, errs} !== {exp_ack, exp_err}) begin
            n_fail++; $display("FAIL rand_resp c=%0d: acks %b errs %b expected %b %b", c, acks, errs, exp_ack, exp_err);
         end
         n_checks++;
         if ({m0_dat_o, m1_dat_o, m2_dat_o} !== {3{s_dat_i}}) begin
            n_fail++; $display("FAIL rand_rdata c=%0d: %h %h %h expected %h", c, m0_dat_o, m1_dat_o, m2_dat_o, s_dat_i);
         end
         // Reference model of the arbitration rules for the next cycle.
         if (owner < 0) begin
            for (int j = 1; j <= 3; j++) begin
               k = (last + j) % 3;
               if (req[k]) begin owner = k; holds = 0; stall = 0; break; end
            end
         end else begin
            others = 1'b0;
            for (int m = 0; m < 3; m++) if (m != owner && req[m]) others = 1'b1;
            if (fire || !cyc[owner] ||
                (holds >= MAX_HOLD && !s_ack_i && others && !adr[owner][PAGE_BIT])) begin
               last = owner; owner = -1;
            end else begin
               if (s_ack_i && holds < 255) holds++;
               stall = (s_ack_i || !stb[owner]) ? 0 : stall + 1;
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s_dat_i = 32'h0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_preempt();
      test_page_burst();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
